// File: rtl/alu_sequencer_pkg.sv
// ============================================================================
// Module      : alu_sequencer_pkg
// Description : Shared opcodes, state encodings and defaults for the ALU
//               sequencer and its register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_sequencer_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int NREGS_DEF = 8;
    localparam int AW_DEF    = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SHL = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    // Shift and rotate leave the ALU carry undefined, so the latched carry
    // must survive those operations untouched.
    function automatic logic op_keeps_carry(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_ROR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_regfile.sv
// ============================================================================
// Module      : alu_sequencer_regfile
// Description : NREGS x WIDTH register file, three asynchronous read ports,
//               writeback and external load with writeback priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer_regfile
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    input  logic [AW-1:0]    rbk_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    output logic [WIDTH-1:0] rbk_data,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    assign ra_data  = regs_q[ra_addr];
    assign rb_data  = regs_q[rb_addr];
    assign rbk_data = regs_q[rbk_addr];

    // Load is applied first so a writeback to the same address overrides it;
    // writes to different addresses both land.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (ld_en) begin
            regs_d[ld_addr] = ld_data;
        end
        if (wb_en) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    // Storage with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module      : alu_sequencer
// Description : Sequences an external combinational ALU through read,
//               execute and writeback over a valid/ready command interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_ra,
    input  logic [AW-1:0]    cmd_rb,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_z,
    input  logic             alu_c,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c,
    output logic             done,
    output logic             busy
);

    state_t           state_q,  state_d;
    logic [2:0]       op_q,     op_d;
    logic [AW-1:0]    rd_q,     rd_d;
    logic [AW-1:0]    ra_q,     ra_d;
    logic [AW-1:0]    rb_q,     rb_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q,  alu_a_d;
    logic [WIDTH-1:0] alu_b_q,  alu_b_d;
    logic [WIDTH-1:0] y_hold_q, y_hold_d;
    logic             z_hold_q, z_hold_d;
    logic             c_hold_q, c_hold_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_c_q, flag_c_d;
    logic             done_q,   done_d;

    logic [WIDTH-1:0] ra_data;
    logic [WIDTH-1:0] rb_data_op;
    logic             wb_en;

    assign wb_en = (state_q == S_WB);

    alu_sequencer_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .ra_addr  (ra_q),
        .rb_addr  (rb_q),
        .rbk_addr (rb_addr),
        .ra_data  (ra_data),
        .rb_data  (rb_data_op),
        .rbk_data (rb_data),
        .wb_en    (wb_en),
        .wb_addr  (rd_q),
        .wb_data  (y_hold_q),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    // Next-state and capture logic for the four-step command sequence.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        y_hold_d = y_hold_q;
        z_hold_d = z_hold_q;
        c_hold_d = c_hold_q;
        result_d = result_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    rd_d    = cmd_rd;
                    ra_d    = cmd_ra;
                    rb_d    = cmd_rb;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // Operands are snapshotted here so writeback cannot disturb them.
                alu_op_d = op_q;
                alu_a_d  = ra_data;
                alu_b_d  = rb_data_op;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                y_hold_d = alu_y;
                z_hold_d = alu_z;
                c_hold_d = alu_c;
                state_d  = S_WB;
            end
            S_WB: begin
                result_d = y_hold_q;
                flag_z_d = z_hold_q;
                if (!op_keeps_carry(op_q)) begin
                    flag_c_d = c_hold_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Controller state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            y_hold_q <= '0;
            z_hold_q <= 1'b0;
            c_hold_q <= 1'b0;
            result_q <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            y_hold_q <= y_hold_d;
            z_hold_q <= z_hold_d;
            c_hold_q <= c_hold_d;
            result_q <= result_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
            done_q   <= done_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign result    = result_q;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer with a behavioural ALU
//               and a register-file/flag reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_ra, cmd_rb;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  rb_addr;
    logic [15:0] rb_data;
    logic [2:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_y;
    logic        alu_z, alu_c;
    logic [15:0] result;
    logic        flag_z, flag_c, done, busy;

    int n_cmp = 0;
    int n_err = 0;
    int last_wait;

    // Reference model state
    logic [15:0] m_regs [8];
    logic        m_z, m_c;
    logic [15:0] m_res;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rb_addr(rb_addr), .rb_data(rb_data),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .alu_z(alu_z), .alu_c(alu_c),
        .result(result), .flag_z(flag_z), .flag_c(flag_c),
        .done(done), .busy(busy)
    );

    // Behavioural ALU: {carry, y}. Shift/rotate carry is arbitrary junk.
    function automatic logic [16:0] alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        case (op)
            3'd0: r = {1'b0, a} + {1'b0, b};
            3'd1: r = {(a < b), a - b};
            3'd2: r = {~(a[15] ^ a[0]), a[14:0], 1'b0};
            3'd3: r = {~(a[15] ^ a[0]), a[0], a[15:1]};
            3'd4: r = {1'b0, a & b};
            3'd5: r = {1'b0, a | b};
            3'd6: r = {1'b0, a ^ b};
            default: r = {1'b0, ~a};
        endcase
        return r;
    endfunction

    assign {alu_c, alu_y} = alu_ref(alu_op, alu_a, alu_b);
    assign alu_z = (alu_y == 16'h0000);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        ld_addr = a; ld_data = d; ld_en = 1'b1;
        tick;
        ld_en = 1'b0;
        m_regs[a] = d;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a);
        rb_addr = a;
        #1;
        chk(tag, {16'h0, rb_data}, {16'h0, m_regs[a]});
    endtask

    // ld_phase: 0 none, 1 load on the READ edge, 3 load on the WB edge.
    task automatic do_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                          input logic [2:0] rb, input bit keep, input int ld_phase,
                          input logic [2:0] la, input logic [15:0] ldv);
        logic [16:0] r;
        logic [15:0] ea, eb;
        int waits;
        cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_valid = 1'b1;
        waits = 0;
        while (!cmd_ready && waits < 20) begin
            tick;
            waits++;
        end
        last_wait = waits;
        if (waits >= 20) begin
            chk("accept_timeout", 32'(waits), 32'd0);
            cmd_valid = 1'b0;
            return;
        end
        ea = m_regs[ra];
        eb = m_regs[rb];
        r  = alu_ref(op, ea, eb);
        tick; // accept edge: now in READ
        if (!keep) cmd_valid = 1'b0;
        chk("read_busy", {31'h0, busy}, 32'd1);
        chk("read_ready", {31'h0, cmd_ready}, 32'd0);
        chk("read_done", {31'h0, done}, 32'd0);
        if (ld_phase == 1) begin
            ld_addr = la; ld_data = ldv; ld_en = 1'b1;
        end
        tick; // now in EXEC
        ld_en = 1'b0;
        if (ld_phase == 1) m_regs[la] = ldv;
        chk("exec_op", {29'h0, alu_op}, {29'h0, op});
        chk("exec_a", {16'h0, alu_a}, {16'h0, ea});
        chk("exec_b", {16'h0, alu_b}, {16'h0, eb});
        chk("exec_ready", {31'h0, cmd_ready}, 32'd0);
        tick; // now in WB
        chk("wb_busy", {31'h0, busy}, 32'd1);
        chk("wb_done", {31'h0, done}, 32'd0);
        if (ld_phase == 3) begin
            ld_addr = la; ld_data = ldv; ld_en = 1'b1;
        end
        tick; // writeback edge
        ld_en = 1'b0;
        if (ld_phase == 3) m_regs[la] = ldv;
        m_regs[rd] = r[15:0];
        m_res = r[15:0];
        m_z = (r[15:0] == 16'h0);
        if (op != 3'd2 && op != 3'd3) m_c = r[16];
        chk("done_pulse", {31'h0, done}, 32'd1);
        chk("done_ready", {31'h0, cmd_ready}, 32'd1);
        chk("done_busy", {31'h0, busy}, 32'd0);
        chk("result", {16'h0, result}, {16'h0, m_res});
        chk("flag_z", {31'h0, flag_z}, {31'h0, m_z});
        chk("flag_c", {31'h0, flag_c}, {31'h0, m_c});
        check_reg("rd_value", rd);
        if (ld_phase != 0 && la != rd) check_reg("ld_value", la);
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; rb_addr = '0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_z = 1'b0; m_c = 1'b0; m_res = 16'h0;
        #1 reset = 1'b1;
        #1;
        chk("rst_ready", {31'h0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_outs", {alu_op, alu_a, flag_z, flag_c}, 32'd0);
        chk("rst_result", {alu_b, result}, 32'd0);
        tick; tick;
        reset = 1'b0;
        check_reg("rst_reg3", 3'd3);

        // Basic add
        load(3'd1, 16'h0005); load(3'd2, 16'h0003);
        do_cmd(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 0, 3'd0, 16'h0);
        chk("add_r3", {16'h0, m_regs[3]}, 32'h0008);

        // Add wrapping to zero with carry, then sub with borrow
        load(3'd1, 16'hFFFF); load(3'd2, 16'h0001);
        do_cmd(3'd0, 3'd4, 3'd1, 3'd2, 1'b0, 0, 3'd0, 16'h0);
        chk("add_wrap_zc", {30'h0, flag_z, flag_c}, 32'd3);
        load(3'd1, 16'h0005); load(3'd2, 16'h0003);
        do_cmd(3'd1, 3'd5, 3'd2, 3'd1, 1'b0, 0, 3'd0, 16'h0);
        chk("sub_result", {16'h0, result}, 32'hFFFE);

        // Shift/rotate preserve carry
        load(3'd6, 16'h8000);
        do_cmd(3'd2, 3'd6, 3'd6, 3'd6, 1'b0, 0, 3'd0, 16'h0);
        chk("shl_c_kept", {31'h0, flag_c}, 32'd1);
        load(3'd0, 16'h0001);
        do_cmd(3'd3, 3'd7, 3'd0, 3'd0, 1'b0, 0, 3'd0, 16'h0);
        chk("ror_result", {16'h0, result}, 32'h8000);

        // Back-to-back commands with cmd_valid held high
        for (int i = 0; i < 6; i++) begin
            do_cmd((i % 2 == 0) ? 3'd0 : 3'd6, 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1, 0, 3'd0, 16'h0);
            if (i > 0) chk("stream_spacing", 32'(last_wait), 32'd0);
        end
        cmd_valid = 1'b0;

        // Load collisions at the WB edge, and non-forwarded load at READ
        do_cmd(3'd0, 3'd3, 3'd1, 3'd2, 1'b0, 3, 3'd3, 16'h1234);
        do_cmd(3'd5, 3'd2, 3'd1, 3'd3, 1'b0, 3, 3'd5, 16'h5A5A);
        do_cmd(3'd1, 3'd4, 3'd1, 3'd2, 1'b0, 1, 3'd1, 16'h7777);
        do_cmd(3'd7, 3'd0, 3'd4, 3'd5, 1'b0, 0, 3'd0, 16'h0);

        // Reset during EXEC aborts the command
        load(3'd7, 16'hAAAA);
        cmd_op = 3'd6; cmd_rd = 3'd7; cmd_ra = 3'd1; cmd_rb = 3'd2; cmd_valid = 1'b1;
        tick; // accepted (controller idle)
        cmd_valid = 1'b0;
        tick; // in EXEC
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'd0);
        chk("abort_ready", {31'h0, cmd_ready}, 32'd1);
        chk("abort_outs", {alu_op, alu_a, flag_z, flag_c}, 32'd0);
        chk("abort_result", {alu_b, result}, 32'd0);
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_z = 1'b0; m_c = 1'b0; m_res = 16'h0;
        check_reg("abort_rd", 3'd7);
        tick;
        chk("abort_no_done", {31'h0, done}, 32'd0);
        reset = 1'b0;
        tick;
        chk("abort_no_done2", {31'h0, done}, 32'd0);
        check_reg("abort_rd_after", 3'd7);
        load(3'd1, 16'h00F0); load(3'd2, 16'h0FF0);
        do_cmd(3'd6, 3'd7, 3'd1, 3'd2, 1'b0, 0, 3'd0, 16'h0);

        // Randomised commands with occasional loads
        for (int i = 0; i < 40; i++) begin
            int nld;
            int ph;
            nld = $urandom_range(0, 2);
            for (int j = 0; j < nld; j++) load(3'($urandom_range(0, 7)), 16'($urandom));
            ph = $urandom_range(0, 2);
            if (ph == 2) ph = 3;
            do_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), 1'b0, ph, 3'($urandom_range(0, 7)), 16'($urandom));
        end
        tick;
        chk("final_done_low", {31'h0, done}, 32'd0);
        for (int i = 0; i < 8; i++) check_reg("final_reg", 3'(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle controller that sequences the team's 16-bit ALU through read, execute and writeback.
- Owns an 8x16 register file and accepts register-to-register commands over a valid/ready handshake.
- Drives the ALU opcode and operands, captures its result, latches the Z/C status flags and writes the result back.
- Sits between the board-level command source (switch/button debouncer or test FSM) and the combinational ALU.

Parameters:
- WIDTH, 16, datapath and register width.
- NREGS, 8, number of registers.
- AW, 3, register address width; must equal log2(NREGS).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  ALU opcode: 000 add, 001 sub, 010 shl, 011 ror, 100 and, 101 or, 110 xor, 111 not.
- cmd_rd  in  AW  destination register.
- cmd_ra  in  AW  source A register.
- cmd_rb  in  AW  source B register.
- ld_en  in  1  external register load strobe.
- ld_addr  in  AW  load address.
- ld_data  in  WIDTH  load data.
- rb_addr  in  AW  readback address.
- rb_data  out  WIDTH  combinational readback of regs[rb_addr].
- alu_op  out  3  opcode to the ALU, registered.
- alu_a  out  WIDTH  operand A to the ALU, registered.
- alu_b  out  WIDTH  operand B to the ALU, registered.
- alu_y  in  WIDTH  ALU result.
- alu_z  in  1  ALU zero flag.
- alu_c  in  1  ALU carry/borrow flag.
- result  out  WIDTH  last written-back value, registered.
- flag_z  out  1  latched zero flag.
- flag_c  out  1  latched carry flag.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE and all registers clear to 0.
  - alu_op=000, alu_a=alu_b=0, result=0, flag_z=0, flag_c=0, done=0, busy=0, cmd_ready=1.
- States: IDLE -> READ -> EXEC -> WB -> IDLE. There is no other path.
- IDLE: cmd_ready=1.
  - When cmd_valid and cmd_ready are high at edge k, capture op/rd/ra/rb and go to READ.
  - cmd_valid with ready low is not accepted; the requester holds it.
- READ: at edge k+1, alu_op<=op, alu_a<=regs[ra], alu_b<=regs[rb]; go to EXEC.
- EXEC: the ALU settles combinationally. At edge k+2, capture alu_y, alu_z and alu_c into internal holding registers; go to WB.
- WB: at edge k+3, regs[rd]<=held y, result<=held y, flag_z<=held z; go to IDLE and set done<=1.
- Carry flag rule: flag_c<=held c except for op 010 and 011. For those two ops the ALU does not define carry, so flag_c is held unchanged.
- done is high for exactly the one cycle after edge k+3. cmd_ready is also high in that cycle.
- Throughput is one command per 4 cycles.
- A new command may be accepted in the same cycle that done is high.
- rd may equal ra or rb. Operands are captured in READ, so the writeback never affects the current operation.
- External load:
  - ld_en is honoured in any state.
  - If ld_en and a WB write target the same address at the same edge, the WB write wins. Different addresses both land.
  - A load at the READ edge is not forwarded; the operand reflects the pre-edge contents.
- For op 111 (not), alu_b is still driven with regs[rb]; its value is don't-care to the ALU.
- Reset mid-operation aborts the command:
  - No writeback and no done pulse occur.
  - The register file clears.
- Widths: all arithmetic is done in the ALU. The controller only moves WIDTH-bit values and never truncates or extends them.

Decomposition:
- Shared package/header holds:
  - Opcode constants OP_ADD..OP_NOT.
  - State encodings S_IDLE, S_READ, S_EXEC, S_WB (2-bit).
  - WIDTH/AW defaults.
  - The list of ops that preserve carry (OP_SHL, OP_ROR).
- Sub-module alu_regfile:
  - NREGS x WIDTH storage with three asynchronous read ports (ra, rb, readback).
  - One write port with WB-over-load priority mux.
  - Asynchronous reset to zero.
- The FSM and the capture registers stay in alu_sequencer.

Test Plan:
- Load r1=0x0005, r2=0x0003; cmd add rd=3 ra=1 rb=2 -> done 4 cycles after accept, r3=0x0008, result=0x0008, Z=0, C=0.
- Load r1=0xFFFF, r2=0x0001; add rd=4 -> r4=0x0000, Z=1, C=1; then sub rd=5 ra=2 rb=1 (0x0003-0x0005 after reloading r1=5, r2=3) -> 0xFFFE, Z=0, C=1.
- With flag_c=1, load r6=0x8000; shl rd=6 ra=6 -> r6=0x0000, Z=1, flag_c stays 1; then ror of 0x0001 -> 0x8000, flag_c still 1.
- Hold cmd_valid high with alternating commands -> cmd_ready low in READ/EXEC/WB, each accept spaced exactly 4 cycles, busy matches.
- ld_en to the same address as rd at the WB edge with 0x1234 -> the WB value lands; ld to a different address in the same cycle -> both values present on readback.
- Assert reset during EXEC of xor -> immediately all outputs 0, no done, destination register 0; after release cmd_ready=1 and the next command runs normally.
